// File: rtl/ibex_register_file_mp.sv
// Multi-read-port flop register file with write-pending scoreboard and clear sequencer.
// Define RF_WR_BYPASS_EN to forward same-cycle write data onto matching read ports.
module ibex_register_file_mp #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          NumRdPorts  = 4,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    localparam int unsigned         NUM_WORDS   = RV32E ? 16 : 32,
    localparam int unsigned         ADDR_WIDTH  = RV32E ? 4 : 5
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumRdPorts*5-1:0]         raddr_i,
    output logic [NumRdPorts*DataWidth-1:0] rdata_o,
    output logic [NumRdPorts-1:0]           rd_busy_o,
    input  logic                            we_i,
    input  logic [4:0]                      waddr_i,
    input  logic [DataWidth-1:0]            wdata_i,
    input  logic                            issue_valid_i,
    input  logic [4:0]                      issue_rd_i,
    output logic [NUM_WORDS-1:0]            pend_o,
    input  logic                            clear_req_i,
    output logic                            clear_busy_o,
    output logic                            err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [NUM_WORDS-1:0]    pend_q, pend_d;
    logic                    err_q, err_d;
    logic [DataWidth-1:0]    rf_q [NUM_WORDS];
    logic [DataWidth-1:0]    rf_d [NUM_WORDS];

    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [ADDR_WIDTH-1:0]   iss_idx;
    logic                    wr_ok;
    logic                    wr_oob;
    logic                    iss_ok;
    logic                    iss_oob;

    // Addresses with bit 4 set do not exist in the 16-entry configuration.
    function automatic logic in_range(input logic [4:0] a);
        return (RV32E == 1'b0) || (a[4] == 1'b0);
    endfunction

    assign wr_idx  = waddr_i[ADDR_WIDTH-1:0];
    assign iss_idx = issue_rd_i[ADDR_WIDTH-1:0];
    assign wr_ok   = we_i && (waddr_i != 5'd0) && in_range(waddr_i);
    assign wr_oob  = we_i && !in_range(waddr_i);
    assign iss_ok  = issue_valid_i && (issue_rd_i != 5'd0) && in_range(issue_rd_i);
    assign iss_oob = issue_valid_i && !in_range(issue_rd_i);

    // Next-state: writes/issues only in IDLE, sweep zeroes one entry per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rf_d    = rf_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = wr_oob || iss_oob;
                if (wr_ok) begin
                    rf_d[wr_idx]   = wdata_i;
                    pend_d[wr_idx] = 1'b0;
                    if (!pend_q[wr_idx]) begin
                        err_d = 1'b1;
                    end
                end
                // Issue after write so a same-address issue (newer instruction) wins.
                if (iss_ok) begin
                    pend_d[iss_idx] = 1'b1;
                end
                if (clear_req_i) begin
                    state_d = SWEEP;
                    idx_d   = ADDR_WIDTH'(1);
                end
            end
            SWEEP: begin
                rf_d[idx_q]   = WordZeroVal;
                pend_d[idx_q] = 1'b0;
                if (idx_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
        endcase
        rf_d[0]   = WordZeroVal;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= ADDR_WIDTH'(1);
            pend_q  <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                rf_q[i] <= WordZeroVal;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            rf_q    <= rf_d;
        end
    end

    // Independent combinational read ports.
    for (genvar p = 0; p < NumRdPorts; p++) begin : g_rd
        logic [4:0]           ra;
        logic [DataWidth-1:0] rd;
        logic                 busy;

        assign ra = raddr_i[5*p +: 5];

        always_comb begin
            rd   = WordZeroVal;
            busy = 1'b0;
            if (in_range(ra)) begin
                rd   = rf_q[ra[ADDR_WIDTH-1:0]];
                busy = pend_q[ra[ADDR_WIDTH-1:0]];
            end
`ifdef RF_WR_BYPASS_EN
            if (wr_ok && (state_q == IDLE) && (ra == waddr_i)) begin
                rd   = wdata_i;
                busy = 1'b0;
            end
`endif
        end

        assign rdata_o[DataWidth*p +: DataWidth] = rd;
        assign rd_busy_o[p]                      = busy;
    end

    assign pend_o       = pend_q;
    assign clear_busy_o = (state_q == SWEEP);
    assign err_o        = err_q;

endmodule
